vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart to the game's VGA output stage. Consumes the registered `hsync`/`vsync`/RGB stream (640x480 at 60 Hz, 25.175 MHz pixel clock, active-low syncs) and recovers pixel coordinates, a visible flag, frame boundaries and a per-frame pixel checksum. Tracks sync timing with a lock FSM and counts timing errors. Used in self-checking benches and as an on-board loopback monitor.

## Interface
- One clock; reset is synchronous and active-high.
- Parameters: none. Timing constants are fixed:
  - H: 640 visible, 16 front porch, 96 sync, 48 back porch, 800 total.
  - V: 480 visible, 10 front porch, 2 sync, 33 back porch, 525 total.
- Ports:
- `clk_25_175_i`  in  1  pixel clock
- `rst_i`  in  1  synchronous active-high reset
- `hsync_i`  in  1  active-low horizontal sync from VGA output
- `vsync_i`  in  1  active-low vertical sync from VGA output
- `red_i`, `green_i`, `blue_i`  in  4 each  pixel colour
- `position_x_o`  out  10  recovered column, 0..799
- `position_y_o`  out  10  recovered row, 0..524
- `visible_o`  out  1  `locked_o` && x<640 && y<480
- `locked_o`  out  1  FSM in LOCKED
- `frame_o`  out  1  one-cycle pulse at end of each locked frame
- `frame_sum_o`  out  16  checksum of last completed frame
- `err_count_o`  out  8  timing error count, saturating at 255

## Operation
- Input registers:
  - `hs_prev`/`vs_prev` hold the previous samples.
  - Falling edge = current input 0 && prev 1.
- Counters `h_q` (mod 800) and `v_q` (mod 525).
- `h_q`/`v_q` after edge k label the sample captured at edge k. The RGB sample is registered alongside.
- Column update, in priority order:
  1. hsync falling edge: load 656.
  2. Otherwise: h+1, wrapping 799 to 0.
- Row update, in priority order:
  1. vsync falling edge: load 490.
  2. h wraps: v+1, wrapping 524 to 0.
  3. Otherwise: hold.
- Expected hsync: low iff new column is in 656..751.
- Expected vsync: low iff new row is in 490..491. Checked only on cycles where the new column is 0.
- FSM states:
  - SEARCH: counters free-run but are not trusted. hsync falling edge → H_LOCK (column loads 656).
  - H_LOCK: each cycle, compare `hsync_i` to expected.
    - Mismatch: error, → SEARCH.
    - vsync falling edge with no hsync mismatch that cycle → LOCKED.
  - LOCKED:
    - hsync mismatch: error, → SEARCH.
    - vsync mismatch at column 0: error, → H_LOCK.
    - hsync mismatch and vsync mismatch in the same cycle: one error only, → SEARCH.
- Error counter: +1 per error cycle, saturates at 255, cleared only by reset.
- Checksum:
  - Accumulator adds `red+green+blue` (zero-extended) for each LOCKED sample with x<640 && y<480, mod 2^16.
  - Frame end = LOCKED && new position (799,524):
    - `frame_o`=1.
    - `frame_sum_o` ← accumulator including that sample's contribution (zero, since it is not visible).
    - Accumulator clears.
- Leaving LOCKED clears the accumulator. `frame_sum_o` holds its last value.

## Timing
- Reset values:
  - All outputs 0.
  - State SEARCH.
  - `hs_prev`/`vs_prev` = 0, so syncs held low through reset produce no edge.
  - Accumulator 0.
- Latency: all outputs are registered and describe the input sample from the previous cycle.
- `frame_o` goes high in the cycle after the (799,524) sample is presented.
- First lock: `locked_o` rises one cycle after the first vsync falling edge that follows a clean hsync edge. Worst case is about 2 frames from reset.
- Reset asserted mid-frame: outputs zero on the next cycle, whatever the inputs.

## Test plan
- Clean stream from the design's vga_timer plus output flops: `locked_o`=1 after the first vsync fall. Thereafter `position_x_o`/`position_y_o` equal the timer position delayed 1 cycle, `err_count_o`=0, and `frame_o` pulses every 420000 cycles.
- All visible pixels red=4'hF, green=blue=0 → every `frame_sum_o` = 16'h5000 (4608000 mod 65536).
- Force `hsync_i` low for 1 cycle at column 100 of a locked frame → `err_count_o`=1, `locked_o`=0 next cycle, relock after the following vsync fall.
- Hold `vsync_i` high for one frame → at row 490 column 0: `err_count_o`+1, state H_LOCK, `frame_sum_o` holds, relock on the next frame's vsync fall.
- Assert `rst_i` mid-frame with both syncs low for 10 cycles, then release → all outputs 0 and no false lock until a genuine high-to-low hsync transition.
- Inject 300 hsync glitches → `err_count_o` stops at 255.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers 640x480@60 pixel position, lock state and frame checksum from a VGA sync stream
module vga_sync_decoder (
  input  logic        clk_25_175_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  output logic [9:0]  position_x_o,
  output logic [9:0]  position_y_o,
  output logic        visible_o,
  output logic        locked_o,
  output logic        frame_o,
  output logic [15:0] frame_sum_o,
  output logic [7:0]  err_count_o
);

  typedef enum logic [1:0] {SEARCH, H_LOCK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_prev, vs_prev;
  logic [9:0]  h_q, v_q, h_d, v_d;
  logic [15:0] acc_q, acc_sum, pix;
  logic        hs_fall, vs_fall, hs_exp, vs_exp, hs_mis, vs_mis;
  logic        err, lock_d, vis_d, frame_d;

  assign hs_fall = hs_prev & ~hsync_i;
  assign vs_fall = vs_prev & ~vsync_i;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (hs_fall)
      h_d = 10'd656;
    else if (h_q == 10'd799)
      h_d = 10'd0;
    else
      h_d = h_q + 10'd1;
    // a column load from an hsync edge suppresses the row advance
    if (vs_fall)
      v_d = 10'd490;
    else if (!hs_fall && h_q == 10'd799)
      v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
  end

  assign hs_exp = !(h_d >= 10'd656 && h_d <= 10'd751);
  assign vs_exp = !(v_d >= 10'd490 && v_d <= 10'd491);
  assign hs_mis = (hsync_i != hs_exp);
  assign vs_mis = (h_d == 10'd0) && (vsync_i != vs_exp);

  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    case (state_q)
      SEARCH: begin
        if (hs_fall)
          state_d = H_LOCK;
      end
      H_LOCK: begin
        if (hs_mis) begin
          err     = 1'b1;
          state_d = SEARCH;
        end else if (vs_fall) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (hs_mis) begin
          err     = 1'b1;
          state_d = SEARCH;
        end else if (vs_mis) begin
          err     = 1'b1;
          state_d = H_LOCK;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign lock_d  = (state_d == LOCKED);
  assign vis_d   = lock_d && (h_d < 10'd640) && (v_d < 10'd480);
  assign frame_d = lock_d && (h_d == 10'd799) && (v_d == 10'd524);
  assign pix     = 16'(red_i) + 16'(green_i) + 16'(blue_i);
  assign acc_sum = acc_q + (vis_d ? pix : 16'd0);

  always_ff @(posedge clk_25_175_i) begin
    if (rst_i) begin
      state_q     <= SEARCH;
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      h_q         <= 10'd0;
      v_q         <= 10'd0;
      acc_q       <= 16'd0;
      visible_o   <= 1'b0;
      frame_o     <= 1'b0;
      frame_sum_o <= 16'd0;
      err_count_o <= 8'd0;
    end else begin
      state_q   <= state_d;
      hs_prev   <= hsync_i;
      vs_prev   <= vsync_i;
      h_q       <= h_d;
      v_q       <= v_d;
      visible_o <= vis_d;
      frame_o   <= frame_d;
      if (frame_d) begin
        frame_sum_o <= acc_sum;
        acc_q       <= 16'd0;
      end else if (!lock_d) begin
        acc_q <= 16'd0;
      end else begin
        acc_q <= acc_sum;
      end
      if (err && err_count_o != 8'd255)
        err_count_o <= err_count_o + 8'd1;
    end
  end

  assign locked_o     = (state_q == LOCKED);
  assign position_x_o = h_q;
  assign position_y_o = v_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder
module tb_vga_sync_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  red = 4'd0, green = 4'd0, blue = 4'd0;
  logic [9:0]  position_x, position_y;
  logic        visible, locked, frame;
  logic [15:0] frame_sum;
  logic [7:0]  err_count;

  vga_sync_decoder dut (
    .clk_25_175_i (clk),
    .rst_i        (rst),
    .hsync_i      (hsync),
    .vsync_i      (vsync),
    .red_i        (red),
    .green_i      (green),
    .blue_i       (blue),
    .position_x_o (position_x),
    .position_y_o (position_y),
    .visible_o    (visible),
    .locked_o     (locked),
    .frame_o      (frame),
    .frame_sum_o  (frame_sum),
    .err_count_o  (err_count)
  );

  always #20 clk = ~clk;

  // mode: 0 none, 1 full locked check, 2 unlocked, 4 locked flag only
  typedef struct {int x; int y; int mode;} exp_t;

  exp_t        sb[$];
  logic [15:0] fq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_frames = 0;
  int          gx = 0, gy = 0;
  logic [15:0] acc_m = 16'd0;
  logic [15:0] last_sum = 16'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    logic vis_e, frm_e;
    e = sb.pop_front();
    if (frame) begin
      n_frames++;
      if (fq.size() == 0) check("frame_unexpected", frame, 1'b0);
      else check("frame_sum", frame_sum, fq.pop_front());
    end
    vis_e = (e.x < 640) && (e.y < 480);
    frm_e = (e.x == 799) && (e.y == 524);
    case (e.mode)
      1: check("pos", {position_x, position_y, locked, visible, frame},
               {10'(e.x), 10'(e.y), 1'b1, vis_e, frm_e});
      2: check("unlocked", {locked, visible, frame}, 3'b000);
      4: check("locked", locked, 1'b1);
      default: ;
    endcase
  endtask

  task automatic px(input int mode, input bit hs_glitch, input bit vs_high);
    logic v_on;
    v_on  = (gx < 640) && (gy < 480);
    hsync = hs_glitch ? 1'b0 : !(gx >= 656 && gx <= 751);
    vsync = vs_high ? 1'b1 : !(gy >= 490 && gy <= 491);
    red   = v_on ? 4'($urandom) : 4'd0;
    green = v_on ? 4'($urandom) : 4'd0;
    blue  = v_on ? 4'($urandom) : 4'd0;
    if (mode == 1 || mode == 4) begin
      if (v_on) acc_m += 16'(red) + 16'(green) + 16'(blue);
    end else begin
      acc_m = 16'd0;
    end
    if (mode == 1 && gx == 799 && gy == 524) begin
      fq.push_back(acc_m);
      last_sum = acc_m;
      acc_m = 16'd0;
    end
    sb.push_back('{gx, gy, mode});
    @(posedge clk);
    @(negedge clk);
    compare_out();
    if (gx == 799) begin
      gx = 0;
      gy = (gy == 524) ? 0 : gy + 1;
    end else begin
      gx = gx + 1;
    end
  endtask

  task automatic row(input int m_first, input int m_rest, input int glitch_col, input bit vs_high);
    int m;
    for (int c = 0; c < 800; c++) begin
      m = (c == 0) ? m_first : m_rest;
      if (glitch_col >= 0 && c == glitch_col) m = 0;
      else if (glitch_col >= 0 && c > glitch_col) m = 2;
      px(m, (glitch_col == c), vs_high);
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_init", {position_x, position_y, visible, locked, frame, frame_sum, err_count}, 64'd0);
    rst = 1'b0;

    // lock: hsync edge on row 489, vsync edge at start of row 490
    gx = 0; gy = 489;
    row(2, 2, -1, 0);
    for (int r = 490; r <= 524; r++) row(1, 1, -1, 0);

    // three visible rows, then jump to vertical blank
    for (int r = 0; r < 3; r++) row(1, 1, -1, 0);
    gy = 489; row(4, 4, -1, 0);
    for (int r = 490; r <= 524; r++) row(1, 1, -1, 0);

    // vsync released early: mismatch at row 491 column 0
    row(1, 1, -1, 0); row(1, 1, -1, 0);
    gy = 489; row(4, 4, -1, 0);
    row(1, 1, -1, 0);
    row(2, 2, -1, 1);
    check("err_vs", err_count, 8'd1);
    check("sum_hold", frame_sum, last_sum);
    gy = 489; row(2, 2, -1, 0);
    row(1, 1, -1, 0);

    // hsync glitch at column 100
    row(1, 1, -1, 0);
    row(1, 1, 100, 0);
    check("err_hs", err_count, 8'd2);
    row(2, 2, -1, 0);
    gy = 489; row(2, 2, -1, 0);
    row(1, 1, -1, 0);
    row(1, 1, -1, 0);
    check("err_relock", err_count, 8'd2);
    for (int c = 0; c < 50; c++) px(1, 0, 0);

    // reset mid-frame with both syncs low
    rst = 1'b1; hsync = 1'b0; vsync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_mid", {position_x, position_y, visible, locked, frame, frame_sum, err_count}, 64'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 6) begin hsync = 1'b1; vsync = 1'b1; end
      @(posedge clk); @(negedge clk);
      check("post_rst", {position_x, position_y, locked}, {10'(k), 10'd0, 1'b0});
    end
    check("err_after_rst", err_count, 8'd0);

    // 300 hsync glitches, one error each
    for (int g = 0; g < 300; g++) begin
      for (int p = 0; p < 4; p++) begin
        hsync = (p != 0);
        @(posedge clk); @(negedge clk);
      end
      if (g == 99) check("err_100", err_count, 8'd100);
    end
    check("err_sat", err_count, 8'd255);
    check("glitch_unlocked", locked, 1'b0);

    check("frame_count", n_frames, 2);
    check("frames_left", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
